// File: rtl/branch_redirect_ctrl_if.sv
// EX-stage branch outcome and fetch redirect bundle for branch_redirect_ctrl.
// The slave modport is the controller side; the master modport drives EX info and fetch_ready.
interface branch_redirect_ctrl_if;
  logic        ex_valid;
  logic        ex_branch;
  logic        ex_jump;
  logic        ex_taken;
  logic        ex_pred_taken;
  logic [31:0] ex_target;
  logic [31:0] ex_pc_plus4;
  logic        fetch_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush_ifid;
  logic        flush_idex;
  logic        stall_ex;
  logic        trap_misaligned;
  logic [31:0] br_count;
  logic [31:0] mispred_count;

  modport master (
    output ex_valid, ex_branch, ex_jump, ex_taken, ex_pred_taken,
           ex_target, ex_pc_plus4, fetch_ready,
    input  redirect_valid, redirect_pc, flush_ifid, flush_idex, stall_ex,
           trap_misaligned, br_count, mispred_count
  );

  modport slave (
    input  ex_valid, ex_branch, ex_jump, ex_taken, ex_pred_taken,
           ex_target, ex_pc_plus4, fetch_ready,
    output redirect_valid, redirect_pc, flush_ifid, flush_idex, stall_ex,
           trap_misaligned, br_count, mispred_count
  );
endinterface

// File: rtl/branch_redirect_ctrl.sv
// EX-stage wrong-path detector: flushes IF/ID and ID/EX and holds a PC redirect until fetch accepts it.
// Optional performance counters are built when BRANCH_PERF_CNT_EN is defined.
module branch_redirect_ctrl (
  input  logic                 clk,
  input  logic                 rst_n,
  branch_redirect_ctrl_if.slave bus
);

  typedef enum logic {IDLE, REDIRECT} state_t;

  state_t      state;
  logic        resolve;
  logic        sel_target;
  logic        misaligned;
  logic [31:0] next_pc;

  always_comb begin
    resolve    = bus.ex_valid &
                 (bus.ex_jump | (bus.ex_branch & (bus.ex_taken != bus.ex_pred_taken)));
    sel_target = bus.ex_jump | (bus.ex_branch & bus.ex_taken);
    next_pc    = sel_target ? bus.ex_target : bus.ex_pc_plus4;
    // Only a taken target can be misaligned; PC+4 of a fetched instruction never is.
    misaligned = sel_target & (bus.ex_target[1:0] != 2'b00);
  end

  // NOTE: state and outputs use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= IDLE;
      bus.redirect_valid  <= 1'b0;
      bus.redirect_pc     <= 32'h0;
      bus.flush_ifid      <= 1'b0;
      bus.flush_idex      <= 1'b0;
      bus.stall_ex        <= 1'b0;
      bus.trap_misaligned <= 1'b0;
    end else begin
      bus.trap_misaligned <= 1'b0;
      case (state)
        IDLE: begin
          bus.redirect_valid <= 1'b0;
          bus.flush_ifid     <= 1'b0;
          bus.flush_idex     <= 1'b0;
          bus.stall_ex       <= 1'b0;
          if (resolve) begin
            if (misaligned) begin
              // Trap path: squash the wrong-path instructions but send no redirect.
              bus.trap_misaligned <= 1'b1;
              bus.flush_ifid      <= 1'b1;
              bus.flush_idex      <= 1'b1;
            end else begin
              state              <= REDIRECT;
              bus.redirect_valid <= 1'b1;
              bus.redirect_pc    <= next_pc;
              bus.flush_ifid     <= 1'b1;
              bus.flush_idex     <= 1'b1;
              bus.stall_ex       <= 1'b1;
            end
          end
        end
        REDIRECT: begin
          // EX inputs belong to wrong-path instructions here and are ignored.
          if (bus.fetch_ready) begin
            state              <= IDLE;
            bus.redirect_valid <= 1'b0;
            bus.flush_ifid     <= 1'b0;
            bus.flush_idex     <= 1'b0;
            bus.stall_ex       <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BRANCH_PERF_CNT_EN
  // NOTE: counters are plain registers, not memories, so they take the async reset like any state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.br_count      <= 32'h0;
      bus.mispred_count <= 32'h0;
    end else if (state == IDLE) begin
      if (bus.ex_valid & bus.ex_branch)
        bus.br_count <= bus.br_count + 32'd1;
      if (resolve & ~misaligned)
        bus.mispred_count <= bus.mispred_count + 32'd1;
    end
  end
`else
  assign bus.br_count      = 32'h0;
  assign bus.mispred_count = 32'h0;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed scoreboard bench for branch_redirect_ctrl; counter expectations follow BRANCH_PERF_CNT_EN.
module tb_branch_redirect_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  branch_redirect_ctrl_if intf ();

  branch_redirect_ctrl dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (intf.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        rv;
    logic [31:0] pc;
    logic        chk_pc;
    logic        fl;
    logic        st;
    logic        tr;
    logic [31:0] br;
    logic [31:0] mp;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] n_br = 0;
  logic [31:0] n_mp = 0;

  function automatic logic [31:0] cnt(input logic [31:0] n);
`ifdef BRANCH_PERF_CNT_EN
    return n;
`else
    return 32'h0;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic rv, input logic [31:0] pc, input logic chk_pc,
                      input logic fl, input logic st, input logic tr);
    exp_t e;
    e.tag = tag; e.rv = rv; e.pc = pc; e.chk_pc = chk_pc;
    e.fl = fl; e.st = st; e.tr = tr;
    e.br = cnt(n_br); e.mp = cnt(n_mp);
    sb.push_back(e);
  endtask

  task automatic pop_compare();
    exp_t e;
    if (sb.size() == 0) begin
      total++; bad++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = sb.pop_front();
    check({e.tag, ".redirect_valid"}, {31'h0, intf.redirect_valid}, {31'h0, e.rv});
    if (e.chk_pc) check({e.tag, ".redirect_pc"}, intf.redirect_pc, e.pc);
    check({e.tag, ".flush_ifid"}, {31'h0, intf.flush_ifid}, {31'h0, e.fl});
    check({e.tag, ".flush_idex"}, {31'h0, intf.flush_idex}, {31'h0, e.fl});
    check({e.tag, ".stall_ex"}, {31'h0, intf.stall_ex}, {31'h0, e.st});
    check({e.tag, ".trap_misaligned"}, {31'h0, intf.trap_misaligned}, {31'h0, e.tr});
    check({e.tag, ".br_count"}, intf.br_count, e.br);
    check({e.tag, ".mispred_count"}, intf.mispred_count, e.mp);
  endtask

  // One clock: drive EX/fetch inputs, queue the expected post-edge outputs, compare #1 after the edge.
  task automatic cyc(input string tag, input logic v, input logic b, input logic j,
                     input logic t, input logic p, input logic [31:0] tgt,
                     input logic [31:0] pc4, input logic fr,
                     input logic e_rv, input logic [31:0] e_pc, input logic chk_pc,
                     input logic e_fl, input logic e_st, input logic e_tr);
    intf.ex_valid      = v;
    intf.ex_branch     = b;
    intf.ex_jump       = j;
    intf.ex_taken      = t;
    intf.ex_pred_taken = p;
    intf.ex_target     = tgt;
    intf.ex_pc_plus4   = pc4;
    intf.fetch_ready   = fr;
    push(tag, e_rv, e_pc, chk_pc, e_fl, e_st, e_tr);
    @(posedge clk);
    #1;
    pop_compare();
  endtask

  initial begin
    intf.ex_valid = 0; intf.ex_branch = 0; intf.ex_jump = 0; intf.ex_taken = 0;
    intf.ex_pred_taken = 0; intf.ex_target = 0; intf.ex_pc_plus4 = 0; intf.fetch_ready = 0;

    #2;
    push("reset", 0, 32'h0, 1, 0, 0, 0);
    pop_compare();
    #10 rst_n = 1'b1;
    @(negedge clk);

    cyc("idle", 0,0,0,0,0, 32'h0, 32'h0, 1,  0, 32'h0, 1, 0, 0, 0);

    n_br = 1; n_mp = 1;
    cyc("beq_taken", 1,1,0,1,0, 32'h100, 32'h14, 1,  1, 32'h100, 1, 1, 1, 0);
    cyc("beq_done",  0,0,0,0,0, 32'h0, 32'h0, 1,     0, 32'h0, 0, 0, 0, 0);

    n_br = 2; n_mp = 2;
    cyc("nt_mispred", 1,1,0,0,1, 32'h300, 32'h44, 0, 1, 32'h44, 1, 1, 1, 0);
    cyc("nt_done",    0,0,0,0,0, 32'h0, 32'h0, 1,     0, 32'h0, 0, 0, 0, 0);

    n_br = 3;
    cyc("pred_ok", 1,1,0,1,1, 32'h300, 32'h48, 1,    0, 32'h0, 0, 0, 0, 0);

    n_mp = 3;
    cyc("jal", 1,0,1,0,0, 32'h200, 32'h60, 0,        1, 32'h200, 1, 1, 1, 0);
    for (int i = 0; i < 3; i++)
      cyc("bp_hold", 1,1,0,1,0, 32'h500, 32'h64, 0,  1, 32'h200, 1, 1, 1, 0);
    cyc("bp_done", 1,1,0,1,0, 32'h500, 32'h64, 1,    0, 32'h0, 0, 0, 0, 0);

    n_br = 4; n_mp = 4;
    cyc("b2b", 1,1,0,1,0, 32'h80, 32'h204, 0,        1, 32'h80, 1, 1, 1, 0);
    cyc("b2b_done", 0,0,0,0,0, 32'h0, 32'h0, 1,      0, 32'h0, 0, 0, 0, 0);

    cyc("misalign", 1,0,1,0,0, 32'h102, 32'h88, 1,   0, 32'h0, 0, 1, 0, 1);
    cyc("misalign_after", 0,0,0,0,0, 32'h0, 32'h0, 1, 0, 32'h0, 0, 0, 0, 0);
    cyc("nonbranch", 1,0,0,0,0, 32'h0, 32'h8c, 1,    0, 32'h0, 0, 0, 0, 0);
    cyc("invalid_junk", 0,1,1,1,0, 32'h104, 32'h90, 1, 0, 32'h0, 0, 0, 0, 0);

    n_br = 5; n_mp = 5;
    cyc("pre_reset", 1,1,0,1,0, 32'h100, 32'h94, 0,  1, 32'h100, 1, 1, 1, 0);
    #3 rst_n = 1'b0;
    n_br = 0; n_mp = 0;
    #1;
    push("mid_reset", 0, 32'h0, 1, 0, 0, 0);
    pop_compare();
    #3 rst_n = 1'b1;
    cyc("post_reset", 0,0,0,0,0, 32'h0, 32'h0, 0,   0, 32'h0, 1, 0, 0, 0);

`ifdef BRANCH_PERF_CNT_EN
    force intf.br_count = 32'hFFFF_FFFF;
    #1 release intf.br_count;
    n_br = 32'h0;
    cyc("wrap", 1,1,0,0,0, 32'h400, 32'h98, 1,       0, 32'h0, 0, 0, 0, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_redirect_ctrl.md
# branch_redirect_ctrl

Sequencing controller for the EX-stage branch decision. It takes the resolved branch outcome from the branch unit, plus jump and prediction information, and detects when the front end fetched down the wrong path. On a wrong path it flushes the IF/ID and ID/EX pipeline registers and drives a held PC redirect to the fetch stage until fetch accepts it. It sits between the EX stage and the PC/fetch logic of the pipelined core.

## Interface
- No parameters; address width fixed at 32.
- `clk` in 1: core clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ex_valid` in 1: EX stage holds a valid instruction this cycle.
- `ex_branch` in 1: EX instruction is a conditional branch (Branch control bit).
- `ex_jump` in 1: EX instruction is JAL/JALR.
- `ex_taken` in 1: resolved branch outcome (Branch_Bit from the branch unit).
- `ex_pred_taken` in 1: fetch predicted taken for this instruction; tie to 0 with no predictor.
- `ex_target` in 32: computed branch/jump target.
- `ex_pc_plus4` in 32: PC+4 of the EX instruction.
- `fetch_ready` in 1: fetch accepts a redirect this cycle.
- `redirect_valid` out 1: redirect request to fetch.
- `redirect_pc` out 32: new fetch PC; stable while `redirect_valid` is 1.
- `flush_ifid` out 1: kill the IF/ID register contents.
- `flush_idex` out 1: kill the ID/EX register contents.
- `stall_ex` out 1: hold EX/MEM issue while a redirect is pending.
- `trap_misaligned` out 1: one-cycle pulse when the redirect target is not word-aligned.
- `br_count` out 32: conditional branches resolved.
- `mispred_count` out 32: redirects issued.

## Operation
- FSM states are IDLE and REDIRECT. All outputs are registered.
- Resolve event (IDLE only): `ex_valid & (ex_jump | (ex_branch & (ex_taken != ex_pred_taken)))`.
- Redirect PC selection:
  - `ex_target` if `ex_jump`, or if `ex_branch & ex_taken`.
  - Otherwise `ex_pc_plus4`, which covers a branch predicted taken that resolves not-taken.
- Misaligned target: if the selected PC is `ex_target` and `ex_target[1:0] != 2'b00`:
  - Pulse `trap_misaligned` for one cycle.
  - Pulse `flush_ifid` and `flush_idex` for that same cycle.
  - Issue no redirect and stay in IDLE.
- Aligned resolve event: go to REDIRECT and latch `redirect_pc`.
- In REDIRECT, `redirect_valid`, `flush_ifid`, `flush_idex` and `stall_ex` are all 1 every cycle.
- Handshake completes in a cycle where `redirect_valid & fetch_ready`; the next state is IDLE.
- In REDIRECT, `ex_*` inputs are ignored (wrong-path instructions): no event, no count.
- Correctly predicted branches and non-branch instructions produce no outputs.
- When `ex_valid` is 0, all `ex_*` inputs are don't-care.

## Timing
- Reset (asynchronous, immediate): state IDLE, all outputs 0 (`redirect_pc` 0, counters 0).
- Latency:
  - Resolve at edge t leads to `redirect_valid`, flushes and `stall_ex` high from t+1.
  - Minimum REDIRECT occupancy is 1 cycle, when `fetch_ready` is 1 at t+1.
- `fetch_ready` is sampled combinationally in REDIRECT. It is don't-care in IDLE.
- Back-to-back: a resolve event in the first IDLE cycle after REDIRECT is accepted normally.
- Reset mid-REDIRECT drops `redirect_valid` immediately. Fetch must treat that as a withdrawn request.
- Counter arithmetic: 32-bit unsigned, wraps 0xFFFFFFFF to 0. Both counters may increment in the same cycle.

## Configuration
- Macro: `BRANCH_PERF_CNT_EN`.
- Defined:
  - `br_count` increments on every IDLE cycle with `ex_valid & ex_branch`.
  - `mispred_count` increments on every aligned resolve event that enters REDIRECT.
- Undefined: counter registers are not built; `br_count` and `mispred_count` are tied to 0. The ports remain.

## Test plan
- Beq taken, not predicted:
  - Stimulus: `ex_valid=1 ex_branch=1 ex_taken=1 ex_pred_taken=0 ex_target=0x00000100`, `fetch_ready=1`.
  - Response: next cycle `redirect_valid=1 redirect_pc=0x00000100`, flushes=1, `stall_ex=1`; IDLE the cycle after; `mispred_count=1`.
- Predicted taken, resolves not-taken:
  - Stimulus: `ex_pc_plus4=0x00000044`, `ex_taken=0 ex_pred_taken=1`.
  - Response: `redirect_pc=0x00000044`.
  - Also: a correctly predicted taken branch gives no redirect, `br_count` +1 only.
- Fetch back-pressure:
  - Stimulus: JAL to 0x00000200, `fetch_ready=0` for 3 cycles then 1; a valid branch is presented meanwhile.
  - Response: `redirect_valid`, flushes and `stall_ex` held 4 cycles; `redirect_pc` stable at 0x00000200; the in-REDIRECT branch is not counted.
- Misaligned target:
  - Stimulus: JALR target 0x00000102.
  - Response: `trap_misaligned` and flushes high for exactly 1 cycle; `redirect_valid` stays 0; state remains IDLE.
- Reset mid-redirect:
  - Stimulus: assert `rst_n=0` asynchronously while `redirect_valid=1` (off clock edge).
  - Response: all outputs 0 immediately; IDLE after release.
- Counter wrap, with `BRANCH_PERF_CNT_EN`:
  - Stimulus: preload via 0xFFFFFFFF branches (forced), then one more.
  - Response: `br_count=0`.
  - Without the macro, both counters read 0 throughout.
